// File: rtl/alu_shift_add_mul.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle,
// fixed WIDTH-cycle run with start/busy/done handshake.
module alu_shift_add_mul #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   P
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]         state_r,  state_s;
  logic [2*WIDTH-1:0] mcand_r,  mcand_s;
  logic [WIDTH-1:0]   mplier_r, mplier_s;
  logic [2*WIDTH-1:0] acc_r,    acc_s;
  logic [CW-1:0]      count_r,  count_s;
  logic [2*WIDTH-1:0] p_r,      p_s;
  logic               busy_r,   busy_s;
  logic               done_r,   done_s;
  logic [2*WIDTH-1:0] sum_s;

  // Next-state and datapath: load on accepted start, one shift-add step per RUN cycle
  always_comb begin
    state_s  = state_r;
    mcand_s  = mcand_r;
    mplier_s = mplier_r;
    acc_s    = acc_r;
    count_s  = count_r;
    p_s      = p_r;
    sum_s    = acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s  = RUN;
          mcand_s  = {{WIDTH{1'b0}}, A};
          mplier_s = B;
          acc_s    = {(2*WIDTH){1'b0}};
          count_s  = {CW{1'b0}};
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        acc_s    = sum_s;
        mcand_s  = mcand_r << 1;
        mplier_s = mplier_r >> 1;
        count_s  = count_r + CW'(1);
        // Last iteration publishes the sum directly so P lands with done.
        if (count_r == LAST) begin
          p_s     = sum_s;
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s == RUN);
    done_s = (state_s == DONE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      count_r  <= {CW{1'b0}};
      p_r      <= {(2*WIDTH){1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      mcand_r  <= mcand_s;
      mplier_r <= mplier_s;
      acc_r    <= acc_s;
      count_r  <= count_s;
      p_r      <= p_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign P    = p_r;

endmodule
